// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial word adder.
package serial_add_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit ripple-carry adder stage.
module nibble_adder
    import serial_add_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout
);

    logic [NIBBLE:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < NIBBLE; gi++) begin : g_bit
        assign s[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = carry[NIBBLE];

endmodule

// File: rtl/serial_word_adder.sv
// Wide-word adder that runs both operands LSB-first through one 4-bit stage,
// one nibble per cycle, with valid/ready handshakes on input and output.
module serial_word_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / NIBBLE;
    localparam int IDXW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             a_msb_reg, b_msb_reg;
    logic             carry_reg, cout_reg, ovf_reg;
    logic [IDXW-1:0]  idx_reg;

    logic [NIBBLE-1:0] stage_s;
    logic              stage_cout;
    logic              accept, last_step;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_step = (idx_reg == IDXW'(NSTEP - 1));

    // Operands are shifted right each step, so the stage always sees bit 0..3.
    nibble_adder u_nibble_adder (
        .a    (a_sh_reg[NIBBLE-1:0]),
        .b    (b_sh_reg[NIBBLE-1:0]),
        .cin  (carry_reg),
        .s    (stage_s),
        .cout (stage_cout)
    );

    for (genvar gi = 0; gi < NSTEP; gi++) begin : g_sum_nibble
        assign sum_next[gi*NIBBLE +: NIBBLE] =
            (state_reg == ADD && idx_reg == IDXW'(gi)) ? stage_s
                                                       : sum_reg[gi*NIBBLE +: NIBBLE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = ADD;
            ADD:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            carry_reg <= cin;
            idx_reg   <= '0;
        end else if (state_reg == ADD) begin
            a_sh_reg  <= a_sh_reg >> NIBBLE;
            b_sh_reg  <= b_sh_reg >> NIBBLE;
            carry_reg <= stage_cout;
            idx_reg   <= idx_reg + 1'b1;
            sum_reg   <= sum_next;
            if (last_step) begin
                // Top nibble's MSB is the final sum sign bit.
                cout_reg <= stage_cout;
                ovf_reg  <= (a_msb_reg == b_msb_reg) && (stage_s[NIBBLE-1] != a_msb_reg);
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed and randomised checks of serial_word_adder at WIDTH=16.
module tb_serial_word_adder;

    localparam int WIDTH = 16;
    localparam int NSTEP = WIDTH / 4;
    localparam int LAT   = NSTEP + 1;   // negedges from accept edge to out_valid

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_word_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts negedges after the accept edge until out_valid; bounded.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 40);
    endtask

    task automatic consume(input int stall);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec,
                          input logic eo, input int gap, input int stall);
        int cnt;
        repeat (gap) @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(cnt);
        check({tag, "_latency"}, cnt, LAT);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        $display("op %s a=%h b=%h cin=%b sum=%h cout=%b ovf=%b", tag, av, bv, cv, sum, cout, ovf);
        consume(stall);
    endtask

    initial begin
        int cnt;
        logic [16:0] full;
        logic [15:0] ra, rb;
        logic        rc, rovf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 0);
        run_op("ripple1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
        run_op("ripple2",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1, 0);
        run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 2);
        run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 0);
        run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0, 0);

        // Back-pressure with a pending offer held through ADD and DONE
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 16'h1111; b = 16'h2222; cin = 1'b0;
        wait_done(cnt);
        check("bp_latency", cnt, LAT);
        for (int i = 0; i < 6; i++) begin
            check("bp_sum", {16'd0, sum}, 32'h0100);
            check("bp_cout", {31'd0, cout}, 32'd0);
            check("bp_ovf", {31'd0, ovf}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        $display("op bp_first a=00ff b=0001 cin=0 sum=%h cout=%b ovf=%b", sum, cout, ovf);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done(cnt);
        check("bp2_latency", cnt, LAT);
        check("bp2_sum", {16'd0, sum}, 32'h3333);
        check("bp2_cout", {31'd0, cout}, 32'd0);
        $display("op bp_pending a=1111 b=2222 cin=0 sum=%h cout=%b ovf=%b", sum, cout, ovf);
        consume(0);

        // Asynchronous reset in the middle of ADD
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        $display("op midrst abandoned sum=%h out_valid=%b", sum, out_valid);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        run_op("postrst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            run_op("rnd", ra, rb, rc, full[15:0], full[16], rovf,
                   $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
